// File: rtl/nios_system_mem_streamer_pkg.sv
// nios_system_mem_streamer_pkg
// Shared definitions for the on-chip memory streamer: default memory
// geometry, data/beat widths and the transfer state enumeration.
package nios_system_mem_streamer_pkg;

    localparam int unsigned ADDR_W_DEFAULT    = 13;
    localparam int unsigned MEM_DEPTH_DEFAULT = 5120;
    localparam int unsigned DATA_W            = 32;
    // Buffered beat = data plus start/end-of-packet markers.
    localparam int unsigned BEAT_W            = DATA_W + 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/nios_system_mem_streamer_fifo.sv
// nios_system_mem_streamer_fifo
// Synchronous output buffer for the streamer. Entries are written at the
// clock edge, so the head entry is always presented from storage (a
// registered output).
// Ports:
//   clk, reset_n        - clock, asynchronous active-low reset
//   flush               - empty the buffer (wins over push/pop)
//   push, push_data     - write one entry (ignored when full)
//   pop                 - consume the head entry (ignored when empty)
//   out_data, out_valid - head entry and non-empty flag
//   count               - current occupancy
module nios_system_mem_streamer_fifo
    import nios_system_mem_streamer_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = BEAT_W
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         out_data,
    output logic                     out_valid,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] store_q [DEPTH];
    logic [WIDTH-1:0] store_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    // DEPTH is a power of two, so the pointers wrap by plain overflow.
    always_comb begin
        store_d  = store_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        do_push  = push && (count_q != CNT_W'(DEPTH));
        do_pop   = pop && (count_q != '0);
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                store_d[wr_ptr_q] = push_data;
                wr_ptr_d          = wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            if (do_push && !do_pop) begin
                count_d = count_q + CNT_W'(1);
            end else if (do_pop && !do_push) begin
                count_d = count_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: nothing is visible until count is non-zero.
    always_ff @(posedge clk) begin
        store_q <= store_d;
    end

    assign out_data  = store_q[rd_ptr_q];
    assign out_valid = (count_q != '0);
    assign count     = count_q;

endmodule

// File: rtl/nios_system_mem_streamer.sv
// nios_system_mem_streamer
// Reads a block of consecutive words from a latency-1 on-chip memory and
// presents them as a packet on a ready/valid stream with sop/eop markers.
// Ports:
//   clk, reset_n                     - clock, asynchronous active-low reset
//   start, start_addr, word_count    - transfer request (accepted in IDLE)
//   abort                            - cancel the active transfer
//   busy, done, error                - status
//   mem_*                            - read-only memory master
//   src_*                            - stream source
module nios_system_mem_streamer
    import nios_system_mem_streamer_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEFAULT,
    parameter int MEM_DEPTH  = MEM_DEPTH_DEFAULT,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W-1:0] word_count,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_chipselect,
    output logic              mem_clken,
    output logic              mem_write,
    output logic [3:0]        mem_byteenable,
    input  logic [31:0]       mem_readdata,
    output logic [31:0]       src_data,
    output logic              src_valid,
    input  logic              src_ready,
    output logic              src_sop,
    output logic              src_eop
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] remain_q, remain_d;
    logic              first_q, first_d;
    logic              inflight_q, inflight_d;
    logic              inflight_sop_q, inflight_sop_d;
    logic              inflight_eop_q, inflight_eop_d;
    logic              error_q, error_d;

    logic              issue;
    logic              abort_hit;
    logic              room;
    logic              start_bad;
    logic              fifo_flush;
    logic              fifo_push;
    logic              fifo_pop;
    logic              fifo_valid;
    logic [BEAT_W-1:0] fifo_out;
    logic [CNT_W-1:0]  fifo_count;

    assign abort_hit = abort && ((state_q == ST_RUN) || (state_q == ST_DRAIN));
    // Reads still in flight will land in the buffer, so they reserve a slot.
    assign room      = (32'(fifo_count) + 32'(inflight_q)) < 32'(FIFO_DEPTH);
    assign start_bad = (32'(start_addr) >= 32'(MEM_DEPTH)) ||
                       (32'(word_count) > 32'(MEM_DEPTH));

    // Transfer sequencing: request validation, read issue with wrap-around
    // addressing, drain of outstanding data and abort handling.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        remain_d   = remain_q;
        first_d    = first_q;
        error_d    = error_q;
        issue      = 1'b0;
        fifo_flush = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    addr_d   = start_addr;
                    remain_d = word_count;
                    first_d  = 1'b1;
                    state_d  = ST_DONE;
                    if (word_count == '0) begin
                        error_d = 1'b0;
                    end else if (start_bad) begin
                        error_d = 1'b1;
                    end else begin
                        error_d = 1'b0;
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                if (abort) begin
                    fifo_flush = 1'b1;
                    error_d    = 1'b1;
                    state_d    = ST_DONE;
                end else if (room) begin
                    issue    = 1'b1;
                    first_d  = 1'b0;
                    remain_d = remain_q - ADDR_W'(1);
                    addr_d   = (addr_q == ADDR_W'(MEM_DEPTH - 1)) ? '0 : addr_q + ADDR_W'(1);
                    if (remain_q == ADDR_W'(1)) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (abort) begin
                    fifo_flush = 1'b1;
                    error_d    = 1'b1;
                    state_d    = ST_DONE;
                end else if (!inflight_q && (fifo_count == '0)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        inflight_d     = issue;
        inflight_sop_d = issue && first_q;
        inflight_eop_d = issue && (remain_q == ADDR_W'(1));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= ST_IDLE;
            addr_q         <= '0;
            remain_q       <= '0;
            first_q        <= 1'b0;
            inflight_q     <= 1'b0;
            inflight_sop_q <= 1'b0;
            inflight_eop_q <= 1'b0;
            error_q        <= 1'b0;
        end else begin
            state_q        <= state_d;
            addr_q         <= addr_d;
            remain_q       <= remain_d;
            first_q        <= first_d;
            inflight_q     <= inflight_d;
            inflight_sop_q <= inflight_sop_d;
            inflight_eop_q <= inflight_eop_d;
            error_q        <= error_d;
        end
    end

    // Data returning for a read issued in an aborted transfer is dropped.
    assign fifo_push = inflight_q && !abort_hit;
    assign fifo_pop  = fifo_valid && src_ready;

    nios_system_mem_streamer_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (BEAT_W)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .flush     (fifo_flush),
        .push      (fifo_push),
        .push_data ({inflight_sop_q, inflight_eop_q, mem_readdata}),
        .pop       (fifo_pop),
        .out_data  (fifo_out),
        .out_valid (fifo_valid),
        .count     (fifo_count)
    );

    assign mem_address    = addr_q;
    assign mem_chipselect = issue;
    assign mem_clken      = 1'b1;
    assign mem_write      = 1'b0;
    assign mem_byteenable = 4'hF;

    assign busy      = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    assign done      = (state_q == ST_DONE);
    assign error     = error_q;
    assign src_data  = fifo_out[DATA_W-1:0];
    assign src_valid = fifo_valid;
    assign src_sop   = fifo_valid && fifo_out[DATA_W+1];
    assign src_eop   = fifo_valid && fifo_out[DATA_W];

endmodule

// File: doc/nios_system_mem_streamer.md
NIOS_SYSTEM_MEM_STREAMER -- requirements
Module: nios_system_mem_streamer

Interface
REQ-001 SHALL have parameter ADDR_W, 13, word-address width of the on-chip memory port.
REQ-002 SHALL have parameter MEM_DEPTH, 5120, number of 32-bit words in the memory.
REQ-003 SHALL have parameter FIFO_DEPTH, 4, output buffer entries (power of two, >=2).
REQ-004 SHALL have port clk, input, 1, single clock for all logic.
REQ-005 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have ports: start, input, 1, one-cycle request pulse; start_addr, input, ADDR_W, first word address; word_count, input, ADDR_W, words to read.
REQ-007 SHALL have port abort, input, 1, one-cycle request to cancel the active transfer.
REQ-008 SHALL have ports: busy, output, 1, transfer active; done, output, 1, one-cycle completion pulse; error, output, 1, status of the last transfer, valid from done onward.
REQ-009 SHALL have memory-master ports: mem_address, output, ADDR_W; mem_chipselect, output, 1; mem_clken, output, 1; mem_write, output, 1; mem_byteenable, output, 4; mem_readdata, input, 32.
REQ-010 SHALL have stream-source ports: src_data, output, 32; src_valid, output, 1; src_ready, input, 1; src_sop, output, 1; src_eop, output, 1.

Function
REQ-011 SHALL drive mem_write=0 and mem_byteenable=4'hF permanently; mem_clken=1 permanently.
REQ-012 SHALL treat memory read latency as exactly 1: mem_readdata for the address issued with mem_chipselect=1 in cycle N is captured at the end of cycle N+1.
REQ-013 SHALL implement FSM IDLE -> RUN -> DRAIN -> DONE -> IDLE; busy=1 in RUN and DRAIN only.
REQ-014 In IDLE, start SHALL latch start_addr and word_count; start while busy SHALL be ignored.
REQ-015 start with word_count=0 SHALL go directly to DONE (done the next cycle, error=0, no reads).
REQ-016 start with start_addr>=MEM_DEPTH or word_count>MEM_DEPTH SHALL go directly to DONE with error=1, no reads.
REQ-017 In RUN, a read SHALL issue only when FIFO occupancy plus in-flight reads < FIFO_DEPTH; at most one read per cycle.
REQ-018 Address SHALL increment by one per issued read and wrap from MEM_DEPTH-1 to 0.
REQ-019 After the last read issues, RUN SHALL go to DRAIN; DRAIN SHALL go to DONE when no read is in flight and the FIFO is empty.
REQ-020 DONE SHALL last one cycle with done=1, then return to IDLE; error SHALL hold until the next accepted start.
REQ-021 A stream beat SHALL transfer when src_valid & src_ready; src_valid SHALL remain stable with data until accepted.
REQ-022 src_sop SHALL mark the first word of a transfer and src_eop the last; both SHALL be 1 for a one-word transfer.
REQ-023 Captured data SHALL emerge on src_data with minimum latency 1 cycle after capture (FIFO output registered).
REQ-024 abort in RUN or DRAIN SHALL stop issuing reads, discard in-flight data, flush the FIFO (src_valid=0 next cycle), and go to DONE with error=1; abort in IDLE/DONE SHALL be ignored.
REQ-025 abort and start in the same cycle in IDLE SHALL be resolved as start.

Reset
REQ-026 On reset_n=0, asynchronously: state=IDLE, busy=0, done=0, error=0, src_valid=0, src_sop=0, src_eop=0, mem_chipselect=0, mem_address=0, FIFO empty, counters 0.
REQ-027 Reset mid-transfer SHALL abandon it with no done pulse; operation resumes on the first clk edge after reset_n rises.

Structure
REQ-028 Package nios_system_mem_streamer_pkg SHALL hold ADDR_W/MEM_DEPTH defaults, data width 32, and the FSM state enumeration.
REQ-029 Output buffer SHALL be one sub-module nios_system_mem_streamer_fifo (synchronous, FIFO_DEPTH x 34 bits incl. sop/eop, flush input).

Verification
REQ-030 start_addr=0x10, word_count=8, src_ready=1, memory holding addr value -> 8 beats 0x10..0x17, sop on first, eop on last, done 1 cycle after last in-flight clears, error=0.
REQ-031 start_addr=5118, word_count=4 -> addresses 5118, 5119, 0, 1 in order, error=0.
REQ-032 word_count=16, src_ready held 0 for 20 cycles -> exactly 4 reads issued, src_valid held with data 0 stable, then all 16 delivered in order after ready=1.
REQ-033 word_count=0 -> done next cycle, error=0, no chipselect; start_addr=5120 -> done, error=1, no chipselect.
REQ-034 abort 3 cycles into a 32-word transfer -> src_valid=0 next cycle, no further chipselect, done with error=1; new start afterwards completes normally.
REQ-035 reset_n pulsed low mid-transfer -> all outputs at reset values immediately, no done pulse, next start completes normally.
